sfifo_byte_packer: RTL and testbench
====================================

// Module: sfifo_byte_packer
// PURPOSE
//  Drains 8-bit bytes from the synchronous FIFO (sfifo_top) read port and
//  packs LANES consecutive bytes into one wide word on a valid/ready output.
//  Sits directly downstream of the FIFO, feeding wide-bus consumers in the
//  benchmark fabric.
//  A flush pulse emits a partial word with a byte-keep mask.
// PARAMETERS
//  BYTE_W  8  width of one FIFO entry / packed lane
//  LANES   4  bytes per output word; power of two, >= 2
// PORTS
//  clk         in   1               rising-edge clock, single clock domain
//  reset       in   1               synchronous, active-high reset
//  fifo_empty  in   1               FIFO empty flag
//  fifo_r_en   out  1               FIFO read enable
//  fifo_data   in   BYTE_W          FIFO data_out; valid 1 cycle after accepted r_en
//  flush       in   1               1-cycle pulse: close current word early
//  word_valid  out  1               output word valid
//  word_ready  in   1               downstream accepts word
//  word_data   out  BYTE_W*LANES    packed word; lane 0 = [BYTE_W-1:0] = oldest byte
//  word_keep   out  LANES           per-lane valid mask
//  word_last   out  1               word was closed by flush
// BEHAVIOUR
//  - Reset values: fifo_r_en 0 (gated by reset), word_valid 0, word_data 0,
//    word_keep 0, word_last 0, fill count 0, pend 0, flush_pend 0.
//  - Reset is synchronous. Mid-operation reset discards partial bytes, the
//    in-flight read and any latched flush.
//  - FSM has two states:
//    - FILL: accumulates bytes.
//    - OUT: word_valid=1. word_data, keep and last stay stable until
//      word_valid && word_ready.
//  - Read issue (combinational):
//    fifo_r_en = FILL && !fifo_empty && !flush_pend && (cnt + pend < LANES).
//    - pend <= fifo_r_en, so one byte can arrive every cycle (no bubbles).
//    - fifo_r_en is never asserted while fifo_empty=1 or in OUT.
//  - Capture: when pend=1, fifo_data is written into lane cnt and cnt increments.
//  - Full word: when cnt reaches LANES -> OUT, keep all ones, last 0.
//  - Flush:
//    - flush sets flush_pend, which blocks new reads.
//    - Once pend=0 and cnt>0 -> OUT with keep = (1<<cnt)-1 and last 1.
//      Unfilled lanes are 0.
//    - Once pend=0 and cnt=0 -> flush_pend clears and no word is emitted.
//    - flush in the same cycle as a capture includes that byte.
//    - flush while in OUT is latched. After the handshake cnt=0, so it
//      clears with no extra word; the current word is not modified.
//  - Handshake in OUT: go to FILL and clear cnt, data, keep and last in the
//    same edge. There is one FILL cycle before the next read.
//  - Throughput: LANES+2 cycles per full word with ready=1 and the FIFO non-empty.
//  - Widths:
//    - cnt is $clog2(LANES)+1 bits; cnt+pend never exceeds LANES.
//    - There is no wrap-around; cnt resets on every handshake.
// STRUCTURE
//  - Shared package sfifo_pkg holds:
//    - BYTE_W and LANES defaults
//    - the FILL/OUT state typedef
//    - a keep_mask(cnt) function
//  - No sub-module: single flat block.
//    - Lane write is an indexed part-select.
//    - FSM and counters live in one clocked process.
//    - fifo_r_en is a combinational assign.
// TESTING
//  - Four bytes, ready=1: reset, then write 01,02,03,04 to FIFO.
//    -> word_data=32'h04030201, keep=4'hF, last=0, word_valid high exactly 1 cycle.
//  - Backpressure: write 01..08, word_ready=0.
//    -> 32'h04030201 held stable and fifo_r_en=0 while in OUT.
//    -> Raise ready: then 32'h08070605 is emitted.
//  - Partial flush: write AA,BB, then pulse flush.
//    -> word_data=32'h0000BBAA, keep=4'b0011, last=1.
//  - Empty flush: flush with cnt=0 and the FIFO empty.
//    -> word_valid stays 0; flush_pend clears next cycle.
//  - Starvation: write 3 bytes, FIFO empty for 10 cycles, then 1 more byte.
//    -> One word with keep=4'hF, and fifo_r_en never high while empty.
//  - Reset mid-fill: reset after 2 captured bytes, then write 11,22,33,44.
//    -> word_data=32'h44332211; no stale lanes.

Source files
------------

// File: rtl/sfifo_pkg.sv
// Shared definitions for the FIFO byte packer: default sizes, FSM state
// encoding and the partial-word keep mask helper.
package sfifo_pkg;

    localparam int BYTE_W_DEF = 8;
    localparam int LANES_DEF  = 4;

    // Two-state packer FSM, kept as plain vector constants for legacy tools
    typedef logic [0:0] state_t;
    localparam state_t ST_FILL = 1'b0;
    localparam state_t ST_OUT  = 1'b1;

    // Low 'cnt' bits set; callers truncate to their lane count (LANES <= 32)
    function automatic logic [31:0] keep_mask(input int unsigned cnt);
        logic [32:0] m;
        m = (33'd1 << cnt) - 33'd1;
        return m[31:0];
    endfunction

endpackage

// File: rtl/sfifo_byte_packer_if.sv
// FIFO read-port and wide-word output bundle for the byte packer.
// master = packer side, slave = FIFO / downstream side.
interface sfifo_byte_packer_if
    import sfifo_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int LANES  = LANES_DEF
);
    logic                    fifo_empty;
    logic                    fifo_r_en;
    logic [BYTE_W-1:0]       fifo_data;
    logic                    flush;
    logic                    word_valid;
    logic                    word_ready;
    logic [BYTE_W*LANES-1:0] word_data;
    logic [LANES-1:0]        word_keep;
    logic                    word_last;

    modport master (
        input  fifo_empty, fifo_data, flush, word_ready,
        output fifo_r_en, word_valid, word_data, word_keep, word_last
    );

    modport slave (
        output fifo_empty, fifo_data, flush, word_ready,
        input  fifo_r_en, word_valid, word_data, word_keep, word_last
    );
endinterface

// File: rtl/sfifo_byte_packer.sv
// Drains bytes from a synchronous FIFO read port and packs LANES of them
// into one wide word (lane 0 = oldest). A flush pulse closes a partial word
// with a keep mask and word_last set.
module sfifo_byte_packer
    import sfifo_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int LANES  = LANES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    sfifo_byte_packer_if.master bus
);

    localparam int CW = $clog2(LANES) + 1;
    localparam int WW = BYTE_W * LANES;
    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_cap;
    logic              pend_q, pend_d;
    logic              flush_pend_q, flush_pend_d;
    logic [WW-1:0]     data_q, data_d;
    logic [LANES-1:0]  keep_q, keep_d;
    logic              last_q, last_d;
    logic              rd_en;

    // Issue a read only when the byte in flight still fits in the word
    assign rd_en = !reset && (state_q == ST_FILL) && !bus.fifo_empty &&
                   !flush_pend_q && ((cnt_q + CW'(pend_q)) < LANES_C);

    assign bus.fifo_r_en  = rd_en;
    assign bus.word_valid = (state_q == ST_OUT);
    assign bus.word_data  = data_q;
    assign bus.word_keep  = keep_q;
    assign bus.word_last  = last_q;

    // Next-state: capture arriving byte, close word on full or pending flush
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = rd_en;
        flush_pend_d = flush_pend_q;
        data_d       = data_q;
        keep_d       = keep_q;
        last_d       = last_q;
        cnt_cap      = cnt_q;
        case (state_q)
            ST_FILL: begin
                if (pend_q) begin
                    data_d[int'(cnt_q[CW-2:0])*BYTE_W +: BYTE_W] = bus.fifo_data;
                    cnt_cap = cnt_q + CW'(1);
                end
                cnt_d = cnt_cap;
                if (bus.flush) flush_pend_d = 1'b1;
                if (cnt_cap == LANES_C) begin
                    // Full word; a pending flush survives and dies on cnt=0
                    state_d = ST_OUT;
                    keep_d  = '1;
                    last_d  = 1'b0;
                end else if (flush_pend_q && !pend_q) begin
                    // No byte in flight: close the partial word (if any)
                    if (cnt_q != '0) begin
                        state_d = ST_OUT;
                        keep_d  = LANES'(keep_mask(32'(cnt_q)));
                        last_d  = 1'b1;
                    end
                    flush_pend_d = bus.flush;
                end
            end
            default: begin
                // Flush during OUT is only latched; the held word is untouched
                if (bus.flush) flush_pend_d = 1'b1;
                if (bus.word_ready) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    data_d  = '0;
                    keep_d  = '0;
                    last_d  = 1'b0;
                end
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FILL;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
            keep_q       <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            flush_pend_q <= flush_pend_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            last_q       <= last_d;
        end
    end

endmodule

// File: tb/tb_sfifo_byte_packer.sv
// Directed bench for sfifo_byte_packer: behavioural FIFO, table of packing
// vectors, plus hand-written backpressure/flush/starvation/reset sequences.
module tb_sfifo_byte_packer;
    import sfifo_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sfifo_byte_packer_if #(.BYTE_W(8), .LANES(4)) bus ();

    sfifo_byte_packer #(.BYTE_W(8), .LANES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural FIFO: data appears one cycle after an accepted r_en
    logic [7:0] mem [0:255];
    int wp = 0;
    int rp = 0;
    assign bus.fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (bus.fifo_r_en) begin
            bus.fifo_data <= mem[rp];
            rp            <= rp + 1;
        end
    end

    // Handshake recorder and protocol monitors
    int cyc = 0;
    int hs_n = 0;
    int vld_cyc = 0;
    int viol = 0;
    logic [31:0] hs_data [0:63];
    logic [3:0]  hs_keep [0:63];
    logic        hs_last [0:63];
    int          hs_cyc  [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.word_valid) vld_cyc <= vld_cyc + 1;
        if (bus.word_valid && bus.word_ready) begin
            hs_data[hs_n] <= bus.word_data;
            hs_keep[hs_n] <= bus.word_keep;
            hs_last[hs_n] <= bus.word_last;
            hs_cyc[hs_n]  <= cyc;
            hs_n          <= hs_n + 1;
        end
        if (bus.fifo_r_en && (bus.fifo_empty || bus.word_valid)) viol <= viol + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 1;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (hs_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (hs_n < target) begin
            errors++;
            $display("FAIL %s: timeout, handshakes got %0d expected %0d", name, hs_n, target);
        end
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [31:0] bytes;
        bit          fl;
        logic [31:0] d;
        logic [3:0]  k;
        bit          l;
    } vec_t;

    vec_t vt [5];

    initial begin
        int h0;
        int v0;
        int bad;

        vt[0] = '{"full4",     4, 32'h04030201, 1'b0, 32'h04030201, 4'hF, 1'b0};
        vt[1] = '{"flush2",    2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'h3, 1'b1};
        vt[2] = '{"flush3",    3, 32'h00302010, 1'b1, 32'h00302010, 4'h7, 1'b1};
        vt[3] = '{"flush1",    1, 32'h0000005A, 1'b1, 32'h0000005A, 4'h1, 1'b1};
        vt[4] = '{"full_then_flush", 4, 32'hDDCCBBAA, 1'b1, 32'hDDCCBBAA, 4'hF, 1'b0};

        // Reset state
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.word_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.word_valid), 32'd0);
        check("rst_data",  bus.word_data, 32'd0);
        check("rst_keep",  32'(bus.word_keep), 32'd0);
        check("rst_last",  32'(bus.word_last), 32'd0);
        check("rst_ren",   32'(bus.fifo_r_en), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven packing vectors, ready held high
        for (int i = 0; i < 5; i++) begin
            h0 = hs_n;
            v0 = vld_cyc;
            for (int j = 0; j < vt[i].n; j++) push(vt[i].bytes[j*8 +: 8]);
            repeat (10) @(negedge clk);
            if (vt[i].fl) pulse_flush();
            wait_hs(h0 + 1, 20, vt[i].name);
            repeat (6) @(negedge clk);
            check({vt[i].name, "_words"}, 32'(hs_n - h0), 32'd1);
            check({vt[i].name, "_data"},  hs_data[h0], vt[i].d);
            check({vt[i].name, "_keep"},  32'(hs_keep[h0]), 32'(vt[i].k));
            check({vt[i].name, "_last"},  32'(hs_last[h0]), 32'(vt[i].l));
            check({vt[i].name, "_vcyc"},  32'(vld_cyc - v0), 32'd1);
        end

        // Backpressure: first word held stable, no reads while in OUT
        bus.word_ready = 1'b0;
        h0 = hs_n;
        for (int j = 1; j <= 8; j++) push(8'(j));
        repeat (10) @(negedge clk);
        check("bp_valid", 32'(bus.word_valid), 32'd1);
        check("bp_data",  bus.word_data, 32'h04030201);
        check("bp_ren",   32'(bus.fifo_r_en), 32'd0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.word_data !== 32'h04030201 || bus.word_valid !== 1'b1) bad++;
        end
        check("bp_stable", 32'(bad), 32'd0);
        bus.word_ready = 1'b1;
        wait_hs(h0 + 2, 30, "bp_two_words");
        @(negedge clk);
        check("bp_word0", hs_data[h0], 32'h04030201);
        check("bp_word1", hs_data[h0 + 1], 32'h08070605);
        check("bp_keep1", 32'(hs_keep[h0 + 1]), 32'hF);
        check("throughput", 32'(hs_cyc[h0 + 1] - hs_cyc[h0]), 32'd6);
        repeat (4) @(negedge clk);

        // Empty flush: latched one cycle, then clears with no word
        v0 = vld_cyc;
        pulse_flush();
        check("eflush_pend1", 32'(dut.flush_pend_q), 32'd1);
        @(negedge clk);
        check("eflush_pend0", 32'(dut.flush_pend_q), 32'd0);
        repeat (5) @(negedge clk);
        check("eflush_novalid", 32'(vld_cyc - v0), 32'd0);

        // Starvation: three bytes, long gap, then the fourth
        h0 = hs_n;
        push(8'h31); push(8'h32); push(8'h33);
        repeat (10) @(negedge clk);
        check("starve_valid", 32'(bus.word_valid), 32'd0);
        check("starve_cnt",   32'(dut.cnt_q), 32'd3);
        push(8'h34);
        wait_hs(h0 + 1, 20, "starve_word");
        @(negedge clk);
        check("starve_data", hs_data[h0], 32'h34333231);
        check("starve_keep", 32'(hs_keep[h0]), 32'hF);
        check("starve_last", 32'(hs_last[h0]), 32'd0);

        // Reset mid-fill discards partial bytes
        push(8'h77); push(8'h88);
        repeat (4) @(negedge clk);
        check("rmf_cnt_pre", 32'(dut.cnt_q), 32'd2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rmf_cnt_rst", 32'(dut.cnt_q), 32'd0);
        reset = 1'b0;
        h0 = hs_n;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_hs(h0 + 1, 20, "rmf_word");
        @(negedge clk);
        check("rmf_data", hs_data[h0], 32'h44332211);
        check("rmf_keep", 32'(hs_keep[h0]), 32'hF);

        check("ren_protocol", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
